mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
- Multi-cycle MIPS main controller; replaces the single-cycle combinational decoder in the next-generation datapath.
- Registered FSM sequences FETCH/DECODE/EXEC/MEM/WB with a ready handshake to a shared instruction/data memory.
- Adds bne, mult, div, mfhi and mflo, with a parametrised multiply/divide latency counter.
- Decodes op/funct from the instruction register (IR) and drives all datapath enables and mux selects.

Parameters:
- MULT_LAT, 5, cycles the MDU needs for mult (>=1).
- DIV_LAT, 10, cycles the MDU needs for div (>=1).
- CNT_W, 4, MDU counter width; requires MULT_LAT and DIV_LAT <= 2^CNT_W.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- op  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag, valid in EXEC.
- mem_ready  in  1  memory completes the current access this cycle.
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, MDU_WAIT=5.
- pc_we  out  1  PC write enable.
- pc_src  out  2  0=PC+4, 1=branch target, 2=jump target, 3=rs.
- ir_we  out  1  IR load.
- iord  out  1  memory address source: 0=PC, 1=ALU result.
- mem_req  out  1  memory access request.
- mem_we  out  1  memory write.
- alu_ctrl  out  5  add=2, sub=6, and=0, or=1, slt=7, lui=9.
- alu_src  out  3  0=rt, 1=sign-ext imm, 2=zero-ext imm, 3=imm<<16.
- reg_we  out  1  register-file write.
- reg_dst  out  2  0=rt, 1=rd, 2=r31.
- mem_to_reg  out  2  0=ALU, 1=mem data, 2=PC (already +4), 3=HI/LO.
- hilo_sel  out  1  0=LO, 1=HI.
- mdu_start  out  1  one-cycle start strobe.
- mdu_op  out  1  0=mult, 1=div.
- mdu_busy  out  1  high exactly while in MDU_WAIT.
- illegal  out  1  one-cycle pulse on an unrecognised opcode.

Behaviour:
- Reset (async): state=FETCH, counter=0. While reset is high every strobe/enable is 0; selects are 0.
- Only state and counter are registered. All other outputs are combinational from state, op, funct, zero and mem_ready; any output not listed for a state is 0.
- FETCH: mem_req=1, iord=0.
  - Hold while mem_ready=0.
  - On mem_ready: ir_we=1, pc_we=1, pc_src=0; next state DECODE.
- DECODE:
  - j: pc_we, pc_src=2.
  - jal: pc_we, pc_src=2, reg_we, reg_dst=2, mem_to_reg=2.
  - jr: pc_we, pc_src=3.
  - nop (op=0, funct=0): no outputs.
  - Unrecognised op/funct: illegal=1.
  - All of the above go to FETCH. Every other instruction goes to EXEC.
- EXEC:
  - R-ALU (add, addu, sub, subu, and, or, slt): alu_src=0 -> WB.
  - addi: alu_src=1, alu_ctrl=2 -> WB.
  - ori: alu_src=2, alu_ctrl=1 -> WB.
  - lui: alu_src=3, alu_ctrl=9 -> WB.
  - lw/sw: alu_src=1, alu_ctrl=2 -> MEM.
  - beq/bne: alu_ctrl=6, pc_src=1; pc_we=zero for beq, ~zero for bne -> FETCH.
  - mult/div: mdu_start=1, mdu_op set; counter loads LAT-1 -> MDU_WAIT.
  - mfhi/mflo: -> WB.
- MEM: mem_req=1, iord=1, mem_we=sw; alu_src and alu_ctrl held as in EXEC.
  - Hold while mem_ready=0.
  - On mem_ready: sw -> FETCH; lw -> WB.
- WB: reg_we=1 for exactly one cycle -> FETCH.
  - R-ALU: reg_dst=1, mem_to_reg=0.
  - I-ALU: reg_dst=0, mem_to_reg=0.
  - lw: reg_dst=0, mem_to_reg=1.
  - mfhi/mflo: reg_dst=1, mem_to_reg=3, hilo_sel=1 for mfhi.
- MDU_WAIT: counter decrements each cycle. When counter=0 -> FETCH.
  - A LAT of 1 spends exactly one cycle in MDU_WAIT.
  - No other state is entered while busy.
- Latency, zero-wait memory: j/jr/jal/nop 2, beq/bne 3, R/I-ALU/mfhi/mflo 4, sw 4, lw 5, mult 3+MULT_LAT, div 3+DIV_LAT.
- mem_ready outside FETCH/MEM is ignored.
- Reset mid-MEM or mid-MDU_WAIT: immediate return to FETCH with the counter cleared. No write strobe may glitch high during reset.
- addu/subu decode identically to add/sub; no overflow trap.

Test Plan:
- Reset released, mem_ready=1, IR add (op=0, funct=0x20) -> states 0,1,2,4,0; in WB reg_we=1, reg_dst=1, alu_ctrl=2 held; pc_we only in FETCH.
- lw (op=0x23) with mem_ready low for 3 cycles in MEM -> MEM held 4 cycles, mem_req=1 and iord=1 throughout; then WB with mem_to_reg=1; total 8 cycles.
- beq with zero=1, then bne with zero=1 -> pc_we=1, pc_src=1 for the beq; pc_we=0 for the bne; both return to FETCH after EXEC.
- div (funct=0x1A) with DIV_LAT=10 -> mdu_start pulse in EXEC, mdu_op=1; mdu_busy high 10 cycles; FETCH reached at cycle 13.
- jal (op=3) -> in DECODE pc_we=1, pc_src=2, reg_we=1, reg_dst=2, mem_to_reg=2; next state FETCH.
- op=0x3F, then reset asserted mid-MDU_WAIT -> illegal pulses one cycle in DECODE; reset forces state=0 asynchronously, all strobes 0.

Source files
------------

// File: rtl/mc_controller_if.sv
// Control bus between the multi-cycle main controller and the MIPS datapath.
// The controller sits on the master side: it takes the decoded IR fields, the
// ALU zero flag and the memory ready handshake, and drives every datapath
// enable and mux select. The datapath (or a bench acting as one) uses slave.
interface mc_controller_if;
  // Datapath -> controller
  logic [5:0] op;          // IR[31:26]
  logic [5:0] funct;       // IR[5:0]
  logic       zero;        // ALU zero flag, meaningful in EXEC
  logic       mem_ready;   // memory completes the current access this cycle

  // Controller -> datapath
  logic [2:0] state;       // FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 MDU_WAIT=5
  logic       pc_we;
  logic [1:0] pc_src;      // 0=PC+4 1=branch 2=jump 3=rs
  logic       ir_we;
  logic       iord;        // memory address: 0=PC 1=ALU result
  logic       mem_req;
  logic       mem_we;
  logic [4:0] alu_ctrl;    // add=2 sub=6 and=0 or=1 slt=7 lui=9
  logic [2:0] alu_src;     // 0=rt 1=sext imm 2=zext imm 3=imm<<16
  logic       reg_we;
  logic [1:0] reg_dst;     // 0=rt 1=rd 2=r31
  logic [1:0] mem_to_reg;  // 0=ALU 1=mem 2=PC+4 3=HI/LO
  logic       hilo_sel;    // 0=LO 1=HI
  logic       mdu_start;
  logic       mdu_op;      // 0=mult 1=div
  logic       mdu_busy;
  logic       illegal;

  modport master (
    input  op, funct, zero, mem_ready,
    output state, pc_we, pc_src, ir_we, iord, mem_req, mem_we, alu_ctrl,
           alu_src, reg_we, reg_dst, mem_to_reg, hilo_sel, mdu_start,
           mdu_op, mdu_busy, illegal
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  state, pc_we, pc_src, ir_we, iord, mem_req, mem_we, alu_ctrl,
           alu_src, reg_we, reg_dst, mem_to_reg, hilo_sel, mdu_start,
           mdu_op, mdu_busy, illegal
  );
endinterface

// File: rtl/mc_controller.sv
// Multi-cycle MIPS main controller.
// Sequences FETCH/DECODE/EXEC/MEM/WB (plus MDU_WAIT for mult/div) and decodes
// op/funct from the instruction register into datapath controls.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous, active-high; forces FETCH and silences all outputs
//   bus   - mc_controller_if.master: IR fields, zero, mem_ready in; controls out
// Only the state and the MDU latency counter are registered; every other
// output is combinational from state, op, funct, zero and mem_ready.
module mc_controller #(
  parameter int MULT_LAT = 5,   // MDU cycles for mult (>=1)
  parameter int DIV_LAT  = 10,  // MDU cycles for div  (>=1)
  parameter int CNT_W    = 4    // both latencies must fit in 2^CNT_W
) (
  input logic              clk,
  input logic              reset,
  mc_controller_if.master  bus
);

  typedef enum logic [2:0] {
    FETCH    = 3'd0,
    DECODE   = 3'd1,
    EXEC     = 3'd2,
    MEM      = 3'd3,
    WB       = 3'd4,
    MDU_WAIT = 3'd5
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J   = 6'h02, OP_JAL = 6'h03,
                         OP_BEQ   = 6'h04, OP_BNE = 6'h05, OP_ADDI = 6'h08,
                         OP_ORI   = 6'h0D, OP_LUI = 6'h0F, OP_LW  = 6'h23,
                         OP_SW    = 6'h2B;
  localparam logic [5:0] F_NOP  = 6'h00, F_JR   = 6'h08, F_MFHI = 6'h10,
                         F_MFLO = 6'h12, F_MULT = 6'h18, F_DIV  = 6'h1A,
                         F_ADD  = 6'h20, F_ADDU = 6'h21, F_SUB  = 6'h22,
                         F_SUBU = 6'h23, F_AND  = 6'h24, F_OR   = 6'h25,
                         F_SLT  = 6'h2A;
  localparam logic [4:0] ALU_AND = 5'd0, ALU_OR = 5'd1, ALU_ADD = 5'd2,
                         ALU_SUB = 5'd6, ALU_SLT = 5'd7, ALU_LUI = 5'd9;

  state_e           state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;

  // Instruction class flags and the ALU setup shared by EXEC, MEM and WB.
  logic       is_ralu, is_addi, is_ori, is_lui, is_lw, is_sw, is_beq, is_bne;
  logic       is_j, is_jal, is_jr, is_nop, is_mult, is_div, is_mfhi, is_mflo;
  logic       is_ialu, is_mfx, legal, ends_in_decode;
  logic [4:0] alu_ctrl_d;
  logic [2:0] alu_src_d;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case statements leaves a variable unassigned (no latches).
    {is_ralu, is_addi, is_ori, is_lui, is_lw, is_sw, is_beq, is_bne} = '0;
    {is_j, is_jal, is_jr, is_nop, is_mult, is_div, is_mfhi, is_mflo} = '0;
    alu_ctrl_d = ALU_AND;
    alu_src_d  = 3'd0;
    case (bus.op)
      OP_RTYPE: begin
        case (bus.funct)
          F_ADD, F_ADDU: begin is_ralu = 1'b1; alu_ctrl_d = ALU_ADD; end
          F_SUB, F_SUBU: begin is_ralu = 1'b1; alu_ctrl_d = ALU_SUB; end
          F_AND:         begin is_ralu = 1'b1; alu_ctrl_d = ALU_AND; end
          F_OR:          begin is_ralu = 1'b1; alu_ctrl_d = ALU_OR;  end
          F_SLT:         begin is_ralu = 1'b1; alu_ctrl_d = ALU_SLT; end
          F_JR:          is_jr   = 1'b1;
          F_NOP:         is_nop  = 1'b1;
          F_MULT:        is_mult = 1'b1;
          F_DIV:         is_div  = 1'b1;
          F_MFHI:        is_mfhi = 1'b1;
          F_MFLO:        is_mflo = 1'b1;
          default: ;
        endcase
      end
      OP_J:    is_j   = 1'b1;
      OP_JAL:  is_jal = 1'b1;
      OP_BEQ:  begin is_beq  = 1'b1; alu_ctrl_d = ALU_SUB; end
      OP_BNE:  begin is_bne  = 1'b1; alu_ctrl_d = ALU_SUB; end
      OP_ADDI: begin is_addi = 1'b1; alu_ctrl_d = ALU_ADD; alu_src_d = 3'd1; end
      OP_ORI:  begin is_ori  = 1'b1; alu_ctrl_d = ALU_OR;  alu_src_d = 3'd2; end
      OP_LUI:  begin is_lui  = 1'b1; alu_ctrl_d = ALU_LUI; alu_src_d = 3'd3; end
      OP_LW:   begin is_lw   = 1'b1; alu_ctrl_d = ALU_ADD; alu_src_d = 3'd1; end
      OP_SW:   begin is_sw   = 1'b1; alu_ctrl_d = ALU_ADD; alu_src_d = 3'd1; end
      default: ;
    endcase
    is_ialu = is_addi | is_ori | is_lui;
    is_mfx  = is_mfhi | is_mflo;
    legal   = is_ralu | is_ialu | is_lw | is_sw | is_beq | is_bne | is_j |
              is_jal | is_jr | is_nop | is_mult | is_div | is_mfx;
    // Jumps, nop and illegal encodings retire in DECODE.
    ends_in_decode = is_j | is_jal | is_jr | is_nop | ~legal;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      cnt_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples its next value from the same pre-edge snapshot.
      state_q <= state_n;
      cnt_q   <= cnt_n;
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    unique case (state_q)
      FETCH:  if (bus.mem_ready) state_n = DECODE;
      DECODE: state_n = ends_in_decode ? FETCH : EXEC;
      EXEC: begin
        if (is_mult) begin
          state_n = MDU_WAIT;
          cnt_n   = CNT_W'(MULT_LAT - 1);
        end else if (is_div) begin
          state_n = MDU_WAIT;
          cnt_n   = CNT_W'(DIV_LAT - 1);
        end else if (is_lw | is_sw) begin
          state_n = MEM;
        end else if (is_beq | is_bne) begin
          state_n = FETCH;
        end else begin
          state_n = WB;
        end
      end
      MEM:    if (bus.mem_ready) state_n = is_sw ? FETCH : WB;
      WB:     state_n = FETCH;
      // The counter holds cycles remaining after this one, so LAT-1 loaded
      // in EXEC gives exactly LAT cycles here.
      MDU_WAIT: begin
        if (cnt_q == '0) state_n = FETCH;
        else             cnt_n   = cnt_q - 1'b1;
      end
      default: state_n = FETCH;
    endcase
  end

  // Output logic; reset gates everything so no strobe can glitch during it.
  always_comb begin
    bus.state      = state_q;
    bus.pc_we      = 1'b0;
    bus.pc_src     = 2'd0;
    bus.ir_we      = 1'b0;
    bus.iord       = 1'b0;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.alu_ctrl   = 5'd0;
    bus.alu_src    = 3'd0;
    bus.reg_we     = 1'b0;
    bus.reg_dst    = 2'd0;
    bus.mem_to_reg = 2'd0;
    bus.hilo_sel   = 1'b0;
    bus.mdu_start  = 1'b0;
    bus.mdu_op     = 1'b0;
    bus.mdu_busy   = 1'b0;
    bus.illegal    = 1'b0;
    if (!reset) begin
      unique case (state_q)
        FETCH: begin
          bus.mem_req = 1'b1;
          bus.ir_we   = bus.mem_ready;
          bus.pc_we   = bus.mem_ready;
        end
        DECODE: begin
          if (is_j | is_jal) begin
            bus.pc_we  = 1'b1;
            bus.pc_src = 2'd2;
          end
          if (is_jal) begin
            bus.reg_we     = 1'b1;
            bus.reg_dst    = 2'd2;
            bus.mem_to_reg = 2'd2;
          end
          if (is_jr) begin
            bus.pc_we  = 1'b1;
            bus.pc_src = 2'd3;
          end
          bus.illegal = ~legal;
        end
        EXEC: begin
          bus.alu_ctrl = alu_ctrl_d;
          bus.alu_src  = alu_src_d;
          if (is_beq | is_bne) begin
            bus.pc_src = 2'd1;
            bus.pc_we  = is_beq ? bus.zero : ~bus.zero;
          end
          bus.mdu_start = is_mult | is_div;
          bus.mdu_op    = is_div;
        end
        MEM: begin
          bus.mem_req  = 1'b1;
          bus.iord     = 1'b1;
          bus.mem_we   = is_sw;
          bus.alu_ctrl = alu_ctrl_d;
          bus.alu_src  = alu_src_d;
        end
        WB: begin
          bus.reg_we     = 1'b1;
          bus.alu_ctrl   = alu_ctrl_d;
          bus.alu_src    = alu_src_d;
          bus.reg_dst    = (is_ralu | is_mfx) ? 2'd1 : 2'd0;
          bus.mem_to_reg = is_lw ? 2'd1 : (is_mfx ? 2'd3 : 2'd0);
          bus.hilo_sel   = is_mfhi;
        end
        MDU_WAIT: bus.mdu_busy = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
module tb_mc_controller;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mc_controller_if bus();

  mc_controller #(.MULT_LAT(5), .DIV_LAT(10), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef enum {S_STATE, S_PCWE, S_PCSRC, S_IRWE, S_IORD, S_MEMREQ, S_MEMWE,
                S_ALUCTRL, S_ALUSRC, S_REGWE, S_REGDST, S_M2R, S_HILO,
                S_MDUSTART, S_MDUOP, S_MDUBUSY, S_ILLEGAL} sig_e;

  typedef struct {
    string       nm;
    int          cyc;
    sig_e        sig;
    logic [31:0] val;
  } exp_t;

  typedef struct {
    string      nm;
    logic [5:0] op, funct;
    logic       zero;
    int         lat;
    logic       d_pcwe; logic [1:0] d_pcsrc; logic d_regwe; logic d_ill;
    bit         has_exec; logic [4:0] e_alu; logic [2:0] e_src; logic e_pcwe;
    bit         has_mem; logic m_we;
    bit         has_wb; logic [1:0] w_dst, w_m2r; logic w_hilo;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] sig_val(sig_e s);
    case (s)
      S_STATE:    return 32'(bus.state);
      S_PCWE:     return 32'(bus.pc_we);
      S_PCSRC:    return 32'(bus.pc_src);
      S_IRWE:     return 32'(bus.ir_we);
      S_IORD:     return 32'(bus.iord);
      S_MEMREQ:   return 32'(bus.mem_req);
      S_MEMWE:    return 32'(bus.mem_we);
      S_ALUCTRL:  return 32'(bus.alu_ctrl);
      S_ALUSRC:   return 32'(bus.alu_src);
      S_REGWE:    return 32'(bus.reg_we);
      S_REGDST:   return 32'(bus.reg_dst);
      S_M2R:      return 32'(bus.mem_to_reg);
      S_HILO:     return 32'(bus.hilo_sel);
      S_MDUSTART: return 32'(bus.mdu_start);
      S_MDUOP:    return 32'(bus.mdu_op);
      S_MDUBUSY:  return 32'(bus.mdu_busy);
      default:    return 32'(bus.illegal);
    endcase
  endfunction

  function automatic vec_t mk(string nm, int op, int funct, int zero, int lat,
                              int d_pcwe, int d_pcsrc, int d_regwe, int d_ill,
                              int has_exec, int e_alu, int e_src, int e_pcwe,
                              int has_mem, int m_we,
                              int has_wb, int w_dst, int w_m2r, int w_hilo);
    vec_t v;
    v.nm = nm; v.op = 6'(op); v.funct = 6'(funct); v.zero = 1'(zero); v.lat = lat;
    v.d_pcwe = 1'(d_pcwe); v.d_pcsrc = 2'(d_pcsrc);
    v.d_regwe = 1'(d_regwe); v.d_ill = 1'(d_ill);
    v.has_exec = 1'(has_exec); v.e_alu = 5'(e_alu); v.e_src = 3'(e_src);
    v.e_pcwe = 1'(e_pcwe);
    v.has_mem = 1'(has_mem); v.m_we = 1'(m_we);
    v.has_wb = 1'(has_wb); v.w_dst = 2'(w_dst); v.w_m2r = 2'(w_m2r);
    v.w_hilo = 1'(w_hilo);
    return v;
  endfunction

  task automatic push(string nm, int cyc, sig_e s, logic [31:0] val);
    exp_t e;
    e.nm = nm; e.cyc = cyc; e.sig = s; e.val = val;
    sb.push_back(e);
  endtask

  task automatic drain(int c);
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc == c) begin
      e = sb.pop_front();
      check(e.nm, sig_val(e.sig), e.val);
    end
  endtask

  // Advance to the next cycle's sampling point (just after the falling edge).
  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  // Entered just after a falling edge with the DUT in FETCH; returns at the
  // sampling point of the FETCH cycle that starts the next instruction.
  task automatic run_vec(vec_t v);
    bus.op = v.op; bus.funct = v.funct; bus.zero = v.zero; bus.mem_ready = 1'b1;
    push({v.nm, " fetch ir_we"}, 0, S_IRWE, 1);
    push({v.nm, " fetch pc_we"}, 0, S_PCWE, 1);
    push({v.nm, " decode state"}, 1, S_STATE, 1);
    push({v.nm, " decode pc_we"}, 1, S_PCWE, 32'(v.d_pcwe));
    push({v.nm, " decode pc_src"}, 1, S_PCSRC, 32'(v.d_pcsrc));
    push({v.nm, " decode reg_we"}, 1, S_REGWE, 32'(v.d_regwe));
    push({v.nm, " decode illegal"}, 1, S_ILLEGAL, 32'(v.d_ill));
    if (v.has_exec) begin
      push({v.nm, " exec state"}, 2, S_STATE, 2);
      push({v.nm, " exec alu_ctrl"}, 2, S_ALUCTRL, 32'(v.e_alu));
      push({v.nm, " exec alu_src"}, 2, S_ALUSRC, 32'(v.e_src));
      push({v.nm, " exec pc_we"}, 2, S_PCWE, 32'(v.e_pcwe));
      push({v.nm, " exec reg_we"}, 2, S_REGWE, 0);
    end
    if (v.has_mem) begin
      push({v.nm, " mem state"}, 3, S_STATE, 3);
      push({v.nm, " mem iord"}, 3, S_IORD, 1);
      push({v.nm, " mem mem_we"}, 3, S_MEMWE, 32'(v.m_we));
    end
    if (v.has_wb) begin
      push({v.nm, " wb state"}, v.lat - 1, S_STATE, 4);
      push({v.nm, " wb reg_we"}, v.lat - 1, S_REGWE, 1);
      push({v.nm, " wb reg_dst"}, v.lat - 1, S_REGDST, 32'(v.w_dst));
      push({v.nm, " wb mem_to_reg"}, v.lat - 1, S_M2R, 32'(v.w_m2r));
      push({v.nm, " wb hilo_sel"}, v.lat - 1, S_HILO, 32'(v.w_hilo));
      push({v.nm, " wb alu_ctrl"}, v.lat - 1, S_ALUCTRL, 32'(v.e_alu));
    end
    push({v.nm, " back to fetch"}, v.lat, S_STATE, 0);
    #1;
    drain(0);
    for (int c = 1; c <= v.lat; c++) begin
      next_cycle();
      drain(c);
    end
    check({v.nm, " scoreboard empty"}, 32'(sb.size()), 0);
    sb.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    reset = 1'b1;
    bus.op = 6'h00; bus.funct = 6'h20; bus.zero = 1'b0; bus.mem_ready = 1'b1;

    // ---- reset state: FETCH, every strobe silenced even with mem_ready high
    #2;
    check("reset state", 32'(bus.state), 0);
    check("reset mem_req", 32'(bus.mem_req), 0);
    check("reset ir_we", 32'(bus.ir_we), 0);
    check("reset pc_we", 32'(bus.pc_we), 0);
    @(negedge clk);
    #1;
    reset = 1'b0;

    // ---- table-driven instruction set
    //        name       op    fn   z lat  dec:pcwe src rwe ill  exe:? alu src pcwe  mem:? we  wb:? dst m2r hi
    vecs.push_back(mk("add",    'h00,'h20,0, 4,  0,0,0,0,  1,2,0,0,  0,0,  1,1,0,0));
    vecs.push_back(mk("addu",   'h00,'h21,0, 4,  0,0,0,0,  1,2,0,0,  0,0,  1,1,0,0));
    vecs.push_back(mk("sub",    'h00,'h22,0, 4,  0,0,0,0,  1,6,0,0,  0,0,  1,1,0,0));
    vecs.push_back(mk("subu",   'h00,'h23,0, 4,  0,0,0,0,  1,6,0,0,  0,0,  1,1,0,0));
    vecs.push_back(mk("and",    'h00,'h24,0, 4,  0,0,0,0,  1,0,0,0,  0,0,  1,1,0,0));
    vecs.push_back(mk("or",     'h00,'h25,0, 4,  0,0,0,0,  1,1,0,0,  0,0,  1,1,0,0));
    vecs.push_back(mk("slt",    'h00,'h2A,0, 4,  0,0,0,0,  1,7,0,0,  0,0,  1,1,0,0));
    vecs.push_back(mk("addi",   'h08,'h00,0, 4,  0,0,0,0,  1,2,1,0,  0,0,  1,0,0,0));
    vecs.push_back(mk("ori",    'h0D,'h00,0, 4,  0,0,0,0,  1,1,2,0,  0,0,  1,0,0,0));
    vecs.push_back(mk("lui",    'h0F,'h00,0, 4,  0,0,0,0,  1,9,3,0,  0,0,  1,0,0,0));
    vecs.push_back(mk("lw",     'h23,'h00,0, 5,  0,0,0,0,  1,2,1,0,  1,0,  1,0,1,0));
    vecs.push_back(mk("sw",     'h2B,'h00,0, 4,  0,0,0,0,  1,2,1,0,  1,1,  0,0,0,0));
    vecs.push_back(mk("beq_z1", 'h04,'h00,1, 3,  0,0,0,0,  1,6,0,1,  0,0,  0,0,0,0));
    vecs.push_back(mk("bne_z1", 'h05,'h00,1, 3,  0,0,0,0,  1,6,0,0,  0,0,  0,0,0,0));
    vecs.push_back(mk("beq_z0", 'h04,'h00,0, 3,  0,0,0,0,  1,6,0,0,  0,0,  0,0,0,0));
    vecs.push_back(mk("bne_z0", 'h05,'h00,0, 3,  0,0,0,0,  1,6,0,1,  0,0,  0,0,0,0));
    vecs.push_back(mk("j",      'h02,'h00,0, 2,  1,2,0,0,  0,0,0,0,  0,0,  0,0,0,0));
    vecs.push_back(mk("jal",    'h03,'h00,0, 2,  1,2,1,0,  0,0,0,0,  0,0,  0,0,0,0));
    vecs.push_back(mk("jr",     'h00,'h08,0, 2,  1,3,0,0,  0,0,0,0,  0,0,  0,0,0,0));
    vecs.push_back(mk("nop",    'h00,'h00,0, 2,  0,0,0,0,  0,0,0,0,  0,0,  0,0,0,0));
    vecs.push_back(mk("bad_op", 'h3F,'h00,0, 2,  0,0,0,1,  0,0,0,0,  0,0,  0,0,0,0));
    vecs.push_back(mk("bad_fn", 'h00,'h3F,0, 2,  0,0,0,1,  0,0,0,0,  0,0,  0,0,0,0));
    vecs.push_back(mk("mfhi",   'h00,'h10,0, 4,  0,0,0,0,  1,0,0,0,  0,0,  1,1,3,1));
    vecs.push_back(mk("mflo",   'h00,'h12,0, 4,  0,0,0,0,  1,0,0,0,  0,0,  1,1,3,0));
    vecs.push_back(mk("mult",   'h00,'h18,0, 8,  0,0,0,0,  1,0,0,0,  0,0,  0,0,0,0));
    vecs.push_back(mk("div",    'h00,'h1A,0,13,  0,0,0,0,  1,0,0,0,  0,0,  0,0,0,0));
    foreach (vecs[i]) run_vec(vecs[i]);

    // ---- FETCH waits for memory, then lw with 3 stall cycles in MEM
    bus.op = 6'h23; bus.funct = 6'h00; bus.mem_ready = 1'b0;
    #1;
    check("fetch stall ir_we", 32'(bus.ir_we), 0);
    check("fetch stall mem_req", 32'(bus.mem_req), 1);
    next_cycle();
    check("fetch stall state", 32'(bus.state), 0);
    bus.mem_ready = 1'b1;
    next_cycle();                                   // cycle 1: DECODE
    next_cycle();                                   // cycle 2: EXEC
    check("lw stall exec", 32'(bus.state), 2);
    for (int c = 3; c <= 6; c++) begin
      next_cycle();
      bus.mem_ready = (c == 6);
      #1;
      check($sformatf("lw stall mem state c%0d", c), 32'(bus.state), 3);
      check($sformatf("lw stall mem_req c%0d", c), 32'(bus.mem_req), 1);
      check($sformatf("lw stall iord c%0d", c), 32'(bus.iord), 1);
    end
    next_cycle();
    check("lw stall wb state", 32'(bus.state), 4);
    check("lw stall wb mem_to_reg", 32'(bus.mem_to_reg), 1);
    next_cycle();
    check("lw stall total 8 cycles", 32'(bus.state), 0);

    // ---- add with mem_ready low outside FETCH: still 4 cycles
    bus.op = 6'h00; bus.funct = 6'h20; bus.mem_ready = 1'b1;
    #1;
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      bus.mem_ready = 1'b0;
    end
    next_cycle();
    check("add ignores mem_ready", 32'(bus.state), 0);
    bus.mem_ready = 1'b1;

    // ---- div: start strobe, 10 busy cycles, FETCH at cycle 13
    bus.op = 6'h00; bus.funct = 6'h1A;
    #1;
    next_cycle();
    next_cycle();
    check("div mdu_start", 32'(bus.mdu_start), 1);
    check("div mdu_op", 32'(bus.mdu_op), 1);
    busy_cnt = 0;
    for (int c = 3; c <= 12; c++) begin
      next_cycle();
      bus.mem_ready = 1'b0;
      #1;
      if (c == 3) check("div start one cycle", 32'(bus.mdu_start), 0);
      if (bus.mdu_busy && bus.state == 3'd5) busy_cnt++;
    end
    check("div busy cycles", 32'(busy_cnt), 10);
    bus.mem_ready = 1'b1;
    next_cycle();
    check("div fetch at 13", 32'(bus.state), 0);
    check("div busy dropped", 32'(bus.mdu_busy), 0);

    // ---- jal write-back fields in DECODE
    bus.op = 6'h03; bus.funct = 6'h00;
    #1;
    next_cycle();
    check("jal reg_dst", 32'(bus.reg_dst), 2);
    check("jal mem_to_reg", 32'(bus.mem_to_reg), 2);
    next_cycle();
    check("jal next fetch", 32'(bus.state), 0);

    // ---- illegal pulses for one cycle only
    bus.op = 6'h3F;
    #1;
    next_cycle();
    check("illegal in decode", 32'(bus.illegal), 1);
    next_cycle();
    check("illegal gone", 32'(bus.illegal), 0);

    // ---- reset mid-MDU_WAIT returns asynchronously to FETCH
    bus.op = 6'h00; bus.funct = 6'h18;
    #1;
    for (int c = 1; c <= 5; c++) next_cycle();
    check("mult in mdu_wait", 32'(bus.state), 5);
    #2;
    reset = 1'b1;
    #1;
    check("async reset state", 32'(bus.state), 0);
    check("async reset busy", 32'(bus.mdu_busy), 0);
    check("async reset mem_req", 32'(bus.mem_req), 0);
    check("async reset reg_we", 32'(bus.reg_we), 0);
    check("async reset mem_we", 32'(bus.mem_we), 0);
    next_cycle();
    reset = 1'b0;
    // Counter must be cleared: a fresh mult still takes exactly 3+MULT_LAT.
    run_vec(vecs[24]);
    run_vec(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
